// File: rtl/bunch_marker_trigger_generator_pkg.sv
// bunch_marker_trigger_generator_pkg: default geometry constants and shared helpers
package bunch_marker_trigger_generator_pkg;
  localparam int DEF_ORBIT_CLOCKS = 1280;
  localparam int DEF_FRAME_DEPTH = 9;
  localparam int DEF_NUM_MARKERS = 4;
  localparam int DEF_POSITION_WIDTH = 11;
  localparam int DEF_PRESCALE_LOG2_WIDTH = 5;
  localparam int DEF_REVO_LOCK_COUNT = 3;
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/bunch_marker_trigger_generator_if.sv
// bunch_marker_trigger_generator_if: revo, configuration and marker/orbit status bundle
interface bunch_marker_trigger_generator_if
  import bunch_marker_trigger_generator_pkg::*;
#(
  parameter int FRAME_DEPTH = DEF_FRAME_DEPTH,
  parameter int NUM_MARKERS = DEF_NUM_MARKERS,
  parameter int POSITION_WIDTH = DEF_POSITION_WIDTH,
  parameter int PRESCALE_LOG2_WIDTH = DEF_PRESCALE_LOG2_WIDTH
);
  logic revo;
  logic trigger_enabled;
  logic [PRESCALE_LOG2_WIDTH-1:0] prescale_log2;
  logic [NUM_MARKERS*POSITION_WIDTH-1:0] marker_position;
  logic [NUM_MARKERS*FRAME_DEPTH-1:0] marker_frame_mask;
  logic trigger;
  logic [NUM_MARKERS-1:0] trigger_marker_id;
  logic frame;
  logic frame_start;
  logic locked;
  logic revo_error;
  logic [31:0] trigger_count;
  modport master (
    output revo, trigger_enabled, prescale_log2, marker_position, marker_frame_mask,
    input trigger, trigger_marker_id, frame, frame_start, locked, revo_error, trigger_count
  );
  modport slave (
    input revo, trigger_enabled, prescale_log2, marker_position, marker_frame_mask,
    output trigger, trigger_marker_id, frame, frame_start, locked, revo_error, trigger_count
  );
endinterface

// File: rtl/bunch_marker_trigger_generator_revo_phase_detector.sv
// bunch_marker_trigger_generator_revo_phase_detector: revo sync, edge detect, lock and timeout tracking
module bunch_marker_trigger_generator_revo_phase_detector
  import bunch_marker_trigger_generator_pkg::*;
#(
  parameter int ORBIT_CLOCKS = DEF_ORBIT_CLOCKS,
  parameter int REVO_LOCK_COUNT = DEF_REVO_LOCK_COUNT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic revo_i,
  input  logic last_i,
  output logic locked_o,
  output logic realign_o,
  output logic revo_error_o
);
  localparam int LCW = $clog2(REVO_LOCK_COUNT + 1);
  localparam int TW = $clog2(2 * ORBIT_CLOCKS);
  localparam logic [TW-1:0] TMAX = TW'(2 * ORBIT_CLOCKS - 1);
  logic [2:0] sync_q;
  logic [LCW-1:0] lock_cnt_q;
  logic [TW-1:0] tmo_q;
  logic locked_q, revo_error_q, rise, timeout;
  always_comb begin
    rise = sync_q[1] & ~sync_q[2];
    realign_o = rise & (~last_i | (~locked_q & (lock_cnt_q == '0)));
    timeout = locked_q & ~rise & (tmo_q == TMAX);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '0;
      lock_cnt_q <= '0;
      tmo_q <= '0;
      locked_q <= 1'b0;
      revo_error_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], revo_i};
      tmo_q <= rise ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + TW'(1));
      revo_error_q <= locked_q & ((rise & ~last_i) | timeout);
      if (realign_o) begin
        lock_cnt_q <= LCW'(1);
        locked_q <= 1'b0;
      end else if (timeout) begin
        lock_cnt_q <= '0;
        locked_q <= 1'b0;
      end else if (rise & ~locked_q) begin
        lock_cnt_q <= lock_cnt_q + LCW'(1);
        locked_q <= (lock_cnt_q + LCW'(1)) == LCW'(REVO_LOCK_COUNT);
      end
    end
  end
  assign locked_o = locked_q;
  assign revo_error_o = revo_error_q;
endmodule

// File: rtl/bunch_marker_trigger_generator.sv
// bunch_marker_trigger_generator: orbit/frame tracking with prescaled, frame-shadowed bunch-marker triggers
module bunch_marker_trigger_generator
  import bunch_marker_trigger_generator_pkg::*;
#(
  parameter int ORBIT_CLOCKS = DEF_ORBIT_CLOCKS,
  parameter int FRAME_DEPTH = DEF_FRAME_DEPTH,
  parameter int NUM_MARKERS = DEF_NUM_MARKERS,
  parameter int POSITION_WIDTH = DEF_POSITION_WIDTH,
  parameter int PRESCALE_LOG2_WIDTH = DEF_PRESCALE_LOG2_WIDTH,
  parameter int REVO_LOCK_COUNT = DEF_REVO_LOCK_COUNT
) (
  input logic clock_i,
  input logic reset_i,
  bunch_marker_trigger_generator_if.slave bus
);
  localparam int CW = $clog2(ORBIT_CLOCKS);
  localparam int PCW = (1 << PRESCALE_LOG2_WIDTH) + 1;
  localparam int FD = FRAME_DEPTH;
  localparam int PW = POSITION_WIDTH;
  localparam logic [FD-1:0] TOKEN_RST = FD'(1) << (FD - 1);
  logic [CW-1:0] cnt_q;
  logic [FD-1:0] token_q;
  logic frame_q, frame_start_q, active_q, trigger_q;
  logic [NUM_MARKERS-1:0] id_q, hit;
  logic [PRESCALE_LOG2_WIDTH-1:0] ps_q;
  logic [NUM_MARKERS*PW-1:0] pos_q;
  logic [NUM_MARKERS*FD-1:0] mask_q;
  logic [PCW-1:0] pcnt_q;
  logic [31:0] tcount_q;
  logic last, boundary, prescale_hit, locked, realign, revo_error;
  bunch_marker_trigger_generator_revo_phase_detector #(
    .ORBIT_CLOCKS(ORBIT_CLOCKS),
    .REVO_LOCK_COUNT(REVO_LOCK_COUNT)
  ) u_revo (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .revo_i(bus.revo),
    .last_i(last),
    .locked_o(locked),
    .realign_o(realign),
    .revo_error_o(revo_error)
  );
  always_comb begin
    last = cnt_q == CW'(ORBIT_CLOCKS - 1);
    boundary = last & token_q[0];
    prescale_hit = pcnt_q >= (PCW'(1) << ps_q);
  end
  // positions beyond the orbit never equal the counter, so they are silently ignored
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_MARKERS; k++)
      hit[k] = active_q & locked & (pos_q[k*PW +: PW] == PW'(cnt_q)) & (|(mask_q[k*FD +: FD] & token_q));
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      token_q <= TOKEN_RST;
      frame_q <= 1'b0;
      frame_start_q <= 1'b0;
      active_q <= 1'b0;
      trigger_q <= 1'b0;
      id_q <= '0;
      ps_q <= '0;
      pos_q <= '0;
      mask_q <= '0;
      pcnt_q <= PCW'(1);
      tcount_q <= '0;
    end else begin
      cnt_q <= (realign | last) ? '0 : cnt_q + CW'(1);
      token_q <= realign ? TOKEN_RST : last ? {token_q[0], token_q[FD-1:1]} : token_q;
      frame_q <= realign | last;
      frame_start_q <= token_q[FD-1];
      trigger_q <= |hit;
      id_q <= hit;
      tcount_q <= trigger_q ? sat_inc32(tcount_q) : tcount_q;
      if (boundary) begin
        ps_q <= bus.prescale_log2;
        pos_q <= bus.marker_position;
        mask_q <= bus.marker_frame_mask;
        if (bus.trigger_enabled) pcnt_q <= prescale_hit ? PCW'(1) : pcnt_q + PCW'(1);
      end
      active_q <= realign ? 1'b0 : boundary ? bus.trigger_enabled & prescale_hit : active_q;
    end
  end
  assign bus.trigger = trigger_q;
  assign bus.trigger_marker_id = id_q;
  assign bus.frame = frame_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked = locked;
  assign bus.revo_error = revo_error;
  assign bus.trigger_count = tcount_q;
endmodule
